// File: rtl/ex_muldiv_pkg.sv
// Shared constants and types for the EX-stage multiply/divide controller.
package ex_muldiv_pkg;

  localparam int MD_NBITS_DEF = 32;
  localparam int MD_NB_MDOP   = 3;
  localparam int MD_NB_CNT    = 6;

  localparam logic [MD_NB_MDOP-1:0] MD_MULT  = 3'd0;
  localparam logic [MD_NB_MDOP-1:0] MD_MULTU = 3'd1;
  localparam logic [MD_NB_MDOP-1:0] MD_DIV   = 3'd2;
  localparam logic [MD_NB_MDOP-1:0] MD_DIVU  = 3'd3;
  localparam logic [MD_NB_MDOP-1:0] MD_MTHI  = 3'd4;
  localparam logic [MD_NB_MDOP-1:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_arith(input logic [MD_NB_MDOP-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// Unsigned iteration datapath: 2*NBITS accumulator shared by shift-add multiply
// and restoring divide, with a down-counter flagging the final step.
module ex_muldiv_core
  import ex_muldiv_pkg::*;
#(
  parameter int NBITS  = MD_NBITS_DEF,
  parameter int NB_CNT = MD_NB_CNT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_is_div,
  input  logic [NBITS-1:0]   i_op_a,
  input  logic [NBITS-1:0]   i_op_b,
  output logic               o_last,
  output logic [2*NBITS-1:0] o_prod,
  output logic [NBITS-1:0]   o_quot,
  output logic [NBITS-1:0]   o_rem
);

  logic [2*NBITS-1:0] r_acc;
  logic [NBITS-1:0]   r_opb;
  logic [NB_CNT-1:0]  r_cnt;
  logic               r_is_div;

  logic [NBITS:0]     w_sum;
  logic [NBITS:0]     w_part;
  logic [NBITS+1:0]   w_diff;
  logic               w_no_borrow;
  logic [2*NBITS-1:0] w_mul_next;
  logic [2*NBITS-1:0] w_div_next;

  // Multiply: r_acc = {partial high, remaining multiplier bits}.
  assign w_sum      = {1'b0, r_acc[2*NBITS-1:NBITS]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_sum, r_acc[NBITS-1:1]};

  // Divide: r_acc = {remainder, dividend bits shifting into quotient bits}.
  assign w_part      = r_acc[2*NBITS-1:NBITS-1];
  assign w_diff      = {1'b0, w_part} - {2'b00, r_opb};
  assign w_no_borrow = ~w_diff[NBITS+1];
  assign w_div_next  = {(w_no_borrow ? w_diff[NBITS-1:0] : w_part[NBITS-1:0]),
                        r_acc[NBITS-2:0], w_no_borrow};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
    end else if (i_load) begin
      r_is_div <= i_is_div;
      r_cnt    <= NB_CNT'(NBITS);
      if (i_is_div) begin
        r_acc <= {{NBITS{1'b0}}, i_op_a};
        r_opb <= i_op_b;
      end else begin
        r_acc <= {{NBITS{1'b0}}, i_op_b};
        r_opb <= i_op_a;
      end
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - NB_CNT'(1);
      r_acc <= r_is_div ? w_div_next : w_mul_next;
    end
  end

  assign o_last = (r_cnt == NB_CNT'(1));
  assign o_prod = r_acc;
  assign o_quot = r_acc[NBITS-1:0];
  assign o_rem  = r_acc[2*NBITS-1:NBITS];

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multiply/divide sequencer beside the EX ALU: owns HI/LO, sign handling and
// the pipeline stall raised while an operation is in flight.
//
//   state   | meaning
//   IDLE    | no op in flight; accepts MULT/DIV (-> RUN) and MTHI/MTLO
//   RUN     | one core iteration per cycle until the counter terminal count
//   FIX     | sign-correct the raw result and write HI/LO, then IDLE
module ex_muldiv_ctrl
  import ex_muldiv_pkg::*;
#(
  parameter int NBITS   = MD_NBITS_DEF,
  parameter int NB_MDOP = MD_NB_MDOP,
  parameter int NB_CNT  = MD_NB_CNT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [NB_MDOP-1:0] i_md_op,
  input  logic [NBITS-1:0]   i_reg1,
  input  logic [NBITS-1:0]   i_reg2,
  input  logic               i_mf_req,
  output logic               o_busy,
  output logic               o_stall,
  output logic [NBITS-1:0]   o_hi,
  output logic [NBITS-1:0]   o_lo
);

  md_state_e          r_state;
  logic               r_busy;
  logic [NBITS-1:0]   r_hi;
  logic [NBITS-1:0]   r_lo;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic [NBITS-1:0]   r_raw1;

  logic               w_arith;
  logic               w_is_div;
  logic               w_signed;
  logic               w_load;
  logic [NBITS-1:0]   w_abs1;
  logic [NBITS-1:0]   w_abs2;
  logic               w_last;
  logic [2*NBITS-1:0] w_prod;
  logic [NBITS-1:0]   w_quot;
  logic [NBITS-1:0]   w_rem;
  logic [2*NBITS-1:0] w_prod_fix;
  logic [NBITS-1:0]   w_quot_fix;
  logic [NBITS-1:0]   w_rem_fix;

  assign w_arith  = md_is_arith(i_md_op);
  assign w_is_div = (i_md_op == MD_DIV) || (i_md_op == MD_DIVU);
  assign w_signed = (i_md_op == MD_MULT) || (i_md_op == MD_DIV);
  assign w_load   = (r_state == ST_IDLE) && i_start && w_arith;

  // Abs of the most negative value stays 0x80.. and is read as unsigned.
  assign w_abs1 = (w_signed && i_reg1[NBITS-1]) ? -i_reg1 : i_reg1;
  assign w_abs2 = (w_signed && i_reg2[NBITS-1]) ? -i_reg2 : i_reg2;

  ex_muldiv_core #(
    .NBITS  (NBITS),
    .NB_CNT (NB_CNT)
  ) u_core (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_load),
    .i_is_div (w_is_div),
    .i_op_a   (w_abs1),
    .i_op_b   (w_abs2),
    .o_last   (w_last),
    .o_prod   (w_prod),
    .o_quot   (w_quot),
    .o_rem    (w_rem)
  );

  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quot_fix = r_neg_q ? -w_quot : w_quot;
  assign w_rem_fix  = r_neg_r ? -w_rem  : w_rem;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_raw1   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (w_arith) begin
              r_state  <= ST_RUN;
              r_busy   <= 1'b1;
              r_is_div <= w_is_div;
              r_neg_q  <= w_signed && (i_reg1[NBITS-1] ^ i_reg2[NBITS-1]);
              r_neg_r  <= w_signed && i_reg1[NBITS-1];
              r_dz     <= w_is_div && (i_reg2 == '0);
              r_raw1   <= i_reg1;
            end else if (i_md_op == MD_MTHI) begin
              r_hi <= i_reg1;
            end else if (i_md_op == MD_MTLO) begin
              r_lo <= i_reg1;
            end
          end
        end
        ST_RUN: begin
          if (w_last) r_state <= ST_FIX;
        end
        ST_FIX: begin
          // Divide by zero reports the raw dividend, bypassing sign fix.
          if (r_dz) begin
            r_hi <= r_raw1;
            r_lo <= '1;
          end else if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot_fix;
          end else begin
            r_hi <= w_prod_fix[2*NBITS-1:NBITS];
            r_lo <= w_prod_fix[NBITS-1:0];
          end
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_stall = r_busy & (i_start | i_mf_req);
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;

endmodule
